// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite N-slave response multiplexer with a built-in default slave for unmapped addresses.
// Optional wait-state watchdog enabled by defining RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux_n #(
    parameter int NUM_SLAVES     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = $clog2(NUM_SLAVES),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic [1:0]                       htrans,
    input  logic [SEL_WIDTH-1:0]             hsel_addr,
    input  logic                             hsel_valid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_bus,
    input  logic [NUM_SLAVES-1:0]            hreadyout_bus,
    input  logic [NUM_SLAVES-1:0]            hresp_bus,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hreadyout,
    output logic                             hresp,
    output logic [SEL_WIDTH-1:0]             data_sel,
    output logic                             timeout
);

    typedef enum logic [1:0] {PASS, ERR1, ERR2} state_t;

    // Channel table padded to a power of two so any index value selects a defined entry.
    localparam int NUM_CH = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] NUM_IDX = (SEL_WIDTH + 1)'(NUM_SLAVES);

    state_t               state_reg, state_next;
    logic [SEL_WIDTH-1:0] data_sel_reg;
    logic                 data_valid_reg;
    logic                 data_active_reg;

    logic [DATA_WIDTH-1:0] ch_rdata [NUM_CH];
    logic [NUM_CH-1:0]     ch_ready;
    logic [NUM_CH-1:0]     ch_resp;

    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  ready_mux;
    logic                  resp_mux;
    logic                  addr_mapped;
    logic                  sel_ready;
    logic                  tout_fire;
    logic                  unused_htrans0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            if (gi < NUM_SLAVES) begin : g_real
                assign ch_rdata[gi] = hrdata_bus[gi*DATA_WIDTH +: DATA_WIDTH];
                assign ch_ready[gi] = hreadyout_bus[gi];
                assign ch_resp[gi]  = hresp_bus[gi];
            end else begin : g_pad
                assign ch_rdata[gi] = '0;
                assign ch_ready[gi] = 1'b1;
                assign ch_resp[gi]  = 1'b0;
            end
        end
    endgenerate

    assign addr_mapped    = hsel_valid && ({1'b0, hsel_addr} < NUM_IDX);
    assign sel_ready      = ch_ready[data_sel_reg];
    assign unused_htrans0 = htrans[0];

    always_comb begin
        rdata_mux  = '0;
        ready_mux  = 1'b1;
        resp_mux   = 1'b0;
        state_next = state_reg;
        case (state_reg)
            PASS: begin
                if (data_valid_reg) begin
                    rdata_mux = ch_rdata[data_sel_reg];
                    ready_mux = sel_ready;
                    resp_mux  = ch_resp[data_sel_reg];
                end
                if (tout_fire) begin
                    state_next = ERR1;
                end else if (ready_mux && htrans[1] && !addr_mapped) begin
                    state_next = ERR1;
                end
            end
            ERR1: begin
                ready_mux  = 1'b0;
                resp_mux   = 1'b1;
                state_next = ERR2;
            end
            ERR2: begin
                resp_mux   = 1'b1;
                state_next = (htrans[1] && !addr_mapped) ? ERR1 : PASS;
            end
            default: state_next = PASS;
        endcase
    end

    // Address phase is accepted only when our own HREADY broadcast is high.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg       <= PASS;
            data_sel_reg    <= '0;
            data_valid_reg  <= 1'b0;
            data_active_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (ready_mux) begin
                data_sel_reg    <= hsel_addr;
                data_valid_reg  <= addr_mapped;
                data_active_reg <= htrans[1];
            end
        end
    end

`ifdef RESP_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             timeout_reg;
    logic             waiting;

    assign waiting   = (state_reg == PASS) && data_valid_reg && data_active_reg && !sel_ready;
    // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
    assign tout_fire = waiting && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= tout_fire;
            if (waiting && !tout_fire) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign tout_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign hrdata    = rdata_mux;
    assign hreadyout = ready_mux;
    assign hresp     = resp_mux;
    assign data_sel  = data_sel_reg;

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Bench for ahb_resp_mux_n: transaction-level response model checked every cycle, plus
// directed literal expectations on a 4-slave and a 5-slave instance.
module tb_ahb_resp_mux_n;

    localparam int DW   = 32;
    localparam int TOUT = 4;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NS   = 2'b10;

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    logic [1:0]      htrans;
    logic [1:0]      hsel_addr;
    logic            hsel_valid;
    logic [4*DW-1:0] hrdata_bus;
    logic [3:0]      hreadyout_bus;
    logic [3:0]      hresp_bus;
    logic [DW-1:0]   hrdata;
    logic            hreadyout;
    logic            hresp;
    logic [1:0]      data_sel;
    logic            timeout;

    logic [2:0]      addr5;
    logic [5*DW-1:0] rdata5_bus;
    logic [4:0]      ready5_bus;
    logic [4:0]      resp5_bus;
    logic [DW-1:0]   rdata5;
    logic            ready5;
    logic            resp5;
    logic [2:0]      sel5;
    logic            tout5;

    ahb_resp_mux_n #(.NUM_SLAVES(4), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TOUT)) u_dut4 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans), .hsel_addr(hsel_addr),
        .hsel_valid(hsel_valid), .hrdata_bus(hrdata_bus), .hreadyout_bus(hreadyout_bus),
        .hresp_bus(hresp_bus), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .data_sel(data_sel), .timeout(timeout)
    );

    ahb_resp_mux_n #(.NUM_SLAVES(5), .DATA_WIDTH(DW)) u_dut5 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans), .hsel_addr(addr5),
        .hsel_valid(hsel_valid), .hrdata_bus(rdata5_bus), .hreadyout_bus(ready5_bus),
        .hresp_bus(resp5_bus), .hrdata(rdata5), .hreadyout(ready5), .hresp(resp5),
        .data_sel(sel5), .timeout(tout5)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each accepted address phase owns the following data phase, which is either a
    // slave's pass-through, a single OKAY cycle, or the two-cycle default-slave ERROR.
    int         m_kind   = 0;    // 0 okay, 1 slave, 2 error
    int         m_idx    = 0;
    bit         m_first  = 1'b0;
    bit         m_active = 1'b0;
    int         m_wait   = 0;
    bit         m_tout   = 1'b0;
    logic [1:0] m_sel    = 2'd0;

    logic [DW-1:0] e_rdata;
    logic          e_ready;
    logic          e_resp;

    always_comb begin
        e_rdata = '0;
        e_ready = 1'b1;
        e_resp  = 1'b0;
        if (m_kind == 1) begin
            e_rdata = hrdata_bus[m_idx*DW +: DW];
            e_ready = hreadyout_bus[m_idx];
            e_resp  = hresp_bus[m_idx];
        end else if (m_kind == 2) begin
            e_ready = !m_first;
            e_resp  = 1'b1;
        end
    end

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_kind <= 0; m_idx <= 0; m_first <= 1'b0; m_active <= 1'b0;
            m_wait <= 0; m_tout <= 1'b0; m_sel <= 2'd0;
        end else begin
            m_tout <= 1'b0;
            if (e_ready) begin
                m_sel    <= hsel_addr;
                m_active <= htrans[1];
                m_wait   <= 0;
                m_first  <= 1'b1;
                if (hsel_valid && int'(hsel_addr) < 4) begin
                    m_kind <= 1;
                    m_idx  <= int'(hsel_addr);
                end else if (htrans[1]) begin
                    m_kind <= 2;
                end else begin
                    m_kind <= 0;
                end
            end else if (m_kind == 2) begin
                m_first <= 1'b0;
            end else if (m_kind == 1 && m_active) begin
`ifdef RESP_MUX_TIMEOUT_EN
                if (m_wait + 1 == TOUT) begin
                    m_kind <= 2; m_first <= 1'b1; m_tout <= 1'b1; m_wait <= 0;
                end else begin
                    m_wait <= m_wait + 1;
                end
`endif
            end
        end
    end

    always @(negedge hclk) begin
        chk("cyc_hrdata", hrdata, e_rdata);
        chk("cyc_hreadyout", 32'(hreadyout), 32'(e_ready));
        chk("cyc_hresp", 32'(hresp), 32'(e_resp));
        chk("cyc_data_sel", 32'(data_sel), 32'(m_sel));
        chk("cyc_timeout", 32'(timeout), 32'(m_tout));
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic [1:0] a, input logic v);
        htrans     = tr;
        hsel_addr  = a;
        hsel_valid = v;
    endtask

    task automatic pin4(input string n, input logic [31:0] rd, input logic rdy,
                        input logic rsp, input logic [1:0] sel);
        #1;
        chk({n, "_hrdata"}, hrdata, rd);
        chk({n, "_hreadyout"}, 32'(hreadyout), 32'(rdy));
        chk({n, "_hresp"}, 32'(hresp), 32'(rsp));
        chk({n, "_data_sel"}, 32'(data_sel), 32'(sel));
    endtask

    task automatic pin5(input string n, input logic [31:0] rd, input logic rdy,
                        input logic rsp, input logic [2:0] sel);
        #1;
        chk({n, "_hrdata"}, rdata5, rd);
        chk({n, "_hreadyout"}, 32'(ready5), 32'(rdy));
        chk({n, "_hresp"}, 32'(resp5), 32'(rsp));
        chk({n, "_data_sel"}, 32'(sel5), 32'(sel));
        chk({n, "_timeout"}, 32'(tout5), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        drive(IDLE, 2'd0, 1'b0);
        hrdata_bus    = {32'd4, 32'd3, 32'd2, 32'd1};
        hreadyout_bus = 4'hF;
        hresp_bus     = 4'b1001;
        addr5         = 3'd0;
        rdata5_bus    = {32'h54, 32'h53, 32'h52, 32'h51, 32'h50};
        ready5_bus    = 5'h1F;
        resp5_bus     = 5'h00;
        hresetn       = 1'b1;
        #1 hresetn    = 1'b0;
        pin4("reset", 32'd0, 1'b1, 1'b0, 2'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        tick(); tick();
        hresetn = 1'b1;

        // Stepping select, one-cycle delayed responses
        drive(NS, 2'd0, 1'b1); tick();
        drive(NS, 2'd1, 1'b1); pin4("t1_s0", 32'd1, 1'b1, 1'b1, 2'd0); tick();
        drive(NS, 2'd2, 1'b1); pin4("t1_s1", 32'd2, 1'b1, 1'b0, 2'd1); tick();
        drive(NS, 2'd3, 1'b1); pin4("t1_s2", 32'd3, 1'b1, 1'b0, 2'd2); tick();
        drive(IDLE, 2'd0, 1'b0); pin4("t1_s3", 32'd4, 1'b1, 1'b1, 2'd3); tick();
        pin4("t1_idle", 32'd0, 1'b1, 1'b0, 2'd0);

        // Slave 2 inserts three wait states while next address phase is held
        drive(NS, 2'd2, 1'b1); tick();
        hreadyout_bus = 4'b1011;
        drive(NS, 2'd1, 1'b1); pin4("t2_w1", 32'd3, 1'b0, 1'b0, 2'd2); tick();
        pin4("t2_w2", 32'd3, 1'b0, 1'b0, 2'd2); tick();
        pin4("t2_w3", 32'd3, 1'b0, 1'b0, 2'd2); tick();
        hreadyout_bus = 4'hF;
        pin4("t2_done", 32'd3, 1'b1, 1'b0, 2'd2); tick();
        drive(IDLE, 2'd0, 1'b0); pin4("t2_next", 32'd2, 1'b1, 1'b0, 2'd1); tick();

        // Unmapped NONSEQ, then IDLE cancel during ERR2
        drive(NS, 2'd1, 1'b0); tick();
        drive(IDLE, 2'd0, 1'b0); pin4("t3_err1", 32'd0, 1'b0, 1'b1, 2'd1); tick();
        pin4("t3_err2", 32'd0, 1'b1, 1'b1, 2'd1); tick();
        pin4("t3_pass", 32'd0, 1'b1, 1'b0, 2'd0);

        // Back-to-back unmapped NONSEQ
        drive(NS, 2'd3, 1'b0); tick();
        pin4("bb_err1a", 32'd0, 1'b0, 1'b1, 2'd3); tick();
        pin4("bb_err2a", 32'd0, 1'b1, 1'b1, 2'd3); tick();
        drive(IDLE, 2'd0, 1'b0); pin4("bb_err1b", 32'd0, 1'b0, 1'b1, 2'd3); tick();
        pin4("bb_err2b", 32'd0, 1'b1, 1'b1, 2'd3); tick();
        pin4("bb_pass", 32'd0, 1'b1, 1'b0, 2'd0);

        // IDLE to unmapped is OKAY; index 6 on the 5-slave instance is unmapped
        drive(IDLE, 2'd2, 1'b0); tick();
        pin4("t4_idle", 32'd0, 1'b1, 1'b0, 2'd2);
        drive(NS, 2'd0, 1'b1); addr5 = 3'd6; tick();
        drive(IDLE, 2'd0, 1'b0); pin5("t4_err1", 32'd0, 1'b0, 1'b1, 3'd6); tick();
        pin5("t4_err2", 32'd0, 1'b1, 1'b1, 3'd6);
        drive(NS, 2'd0, 1'b1); addr5 = 3'd4; tick();
        pin5("t4_slave4", 32'h54, 1'b1, 1'b0, 3'd4);
        drive(IDLE, 2'd0, 1'b0); addr5 = 3'd0; tick();

        // Reset during ERR1 and during a slave wait state
        drive(NS, 2'd3, 1'b0); tick();
        drive(IDLE, 2'd0, 1'b0); pin4("t5_err1", 32'd0, 1'b0, 1'b1, 2'd3);
        hresetn = 1'b0;
        pin4("t5_rst_err", 32'd0, 1'b1, 1'b0, 2'd0);
        pin5("t5_rst5", 32'd0, 1'b1, 1'b0, 3'd0);
        tick(); tick();
        hresetn = 1'b1;
        drive(NS, 2'd2, 1'b1); tick();
        hreadyout_bus = 4'b1011;
        drive(IDLE, 2'd0, 1'b0); pin4("t5_wait", 32'd3, 1'b0, 1'b0, 2'd2);
        hresetn = 1'b0;
        pin4("t5_rst_wait", 32'd0, 1'b1, 1'b0, 2'd0);
        tick();
        hresetn = 1'b1;
        hreadyout_bus = 4'hF;
        drive(NS, 2'd3, 1'b1); tick();
        drive(IDLE, 2'd0, 1'b0); pin4("t5_after", 32'd4, 1'b1, 1'b1, 2'd3); tick();

        // Slave 0 stalls
        drive(NS, 2'd0, 1'b1); tick();
        hreadyout_bus = 4'b1110;
        drive(IDLE, 2'd0, 1'b0);
`ifdef RESP_MUX_TIMEOUT_EN
        for (int w = 0; w < TOUT; w++) begin
            pin4("t6_wait", 32'd1, 1'b0, 1'b1, 2'd0);
            chk("t6_wait_timeout", 32'(timeout), 32'd0);
            tick();
        end
        pin4("t6_err1", 32'd0, 1'b0, 1'b1, 2'd0);
        chk("t6_err1_timeout", 32'(timeout), 32'd1);
        tick();
        pin4("t6_err2", 32'd0, 1'b1, 1'b1, 2'd0);
        chk("t6_err2_timeout", 32'(timeout), 32'd0);
        tick();
        hreadyout_bus = 4'hF;
        pin4("t6_pass", 32'd0, 1'b1, 1'b0, 2'd0);
`else
        for (int w = 0; w < 8; w++) begin
            pin4("t6_stall", 32'd1, 1'b0, 1'b1, 2'd0);
            chk("t6_stall_timeout", 32'(timeout), 32'd0);
            tick();
        end
        hreadyout_bus = 4'hF;
        pin4("t6_release", 32'd1, 1'b1, 1'b1, 2'd0); tick();
        pin4("t6_idle", 32'd0, 1'b1, 1'b0, 2'd0);
`endif
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_resp_mux_n.md
Name: ahb_resp_mux_n

Overview:
- Parametrised AHB-Lite slave-to-master response multiplexer for NUM_SLAVES slaves. Successor to the fixed 4:1 response mux.
- Registers the decoder's address-phase select so the data-phase response is taken from the slave that owns the transfer.
- Contains a built-in default slave that gives the AHB two-cycle ERROR response for unmapped addresses.
- Sits between the slaves and the master; its hreadyout is also broadcast to all slaves as HREADY.

Parameters:
- NUM_SLAVES, 4, number of slave response channels (2..16).
- DATA_WIDTH, 32, hrdata width per slave.
- SEL_WIDTH, $clog2(NUM_SLAVES), width of the slave index.
- TIMEOUT_CYCLES, 16, wait-state limit; used only with RESP_MUX_TIMEOUT_EN.

Ports:
- hclk  in  1  bus clock.
- hresetn  in  1  asynchronous active-low reset.
- htrans  in  2  master transfer type; bit 1 = NONSEQ/SEQ.
- hsel_addr  in  SEL_WIDTH  address-phase slave index from the decoder.
- hsel_valid  in  1  the address decodes to a mapped slave.
- hrdata_bus  in  NUM_SLAVES*DATA_WIDTH  slave read data; slave i is at [i*DATA_WIDTH +: DATA_WIDTH].
- hreadyout_bus  in  NUM_SLAVES  per-slave hreadyout.
- hresp_bus  in  NUM_SLAVES  per-slave hresp (1 = ERROR).
- hrdata  out  DATA_WIDTH  muxed read data.
- hreadyout  out  1  muxed ready; also the HREADY fed back to all slaves.
- hresp  out  1  muxed response.
- data_sel  out  SEL_WIDTH  registered data-phase slave index.
- timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async, hresetn=0):
  - state=PASS; data_sel=0; data_valid=0; data_active=0; wait counter=0.
  - Outputs: hrdata=0, hreadyout=1, hresp=0, timeout=0.
- Address-phase capture happens on the rising hclk edge only when the block's own hreadyout=1:
  - data_sel<=hsel_addr; data_active<=htrans[1].
  - data_valid<=hsel_valid && (hsel_addr<NUM_SLAVES).
  - When hreadyout=0, all three registers hold.
- Indices >= NUM_SLAVES are treated as unmapped.
- FSM states: PASS, ERR1, ERR2.
  - PASS, data_valid=1: hrdata/hreadyout/hresp come combinationally from channel data_sel. Zero added latency; slave wait states pass straight through.
  - PASS, data_valid=0, data_active=0 (IDLE/BUSY to any address): hreadyout=1, hresp=0, hrdata=0.
  - At a capture edge with htrans[1]=1 and the address unmapped: next state = ERR1.
  - ERR1: hreadyout=0, hresp=1, hrdata=0. Always moves to ERR2.
  - ERR2: hreadyout=1, hresp=1, hrdata=0. A capture occurs at the end of this cycle, and the next state is decided from that new address phase: ERR1 again if it is unmapped and active, else PASS.
- Back-to-back:
  - A mapped address phase captured during the last cycle of a slave transfer takes effect on the next cycle with no bubble.
  - Consecutive unmapped NONSEQ transfers give ERR1,ERR2,ERR1,ERR2 repeatedly.
- A master cancelling with IDLE during ERR2 is captured normally and yields PASS/OKAY.
- Slave hresp=1 with hreadyout=0/1 (a slave's own two-cycle error) is passed through unchanged. The mux does not re-time it.
- Reset asserted mid-transfer returns to the reset values immediately, regardless of any slave still in wait states.
- hrdata is don't-care for writes, but is still driven per the rules above (0 in error/idle).

Optional Feature:
- Macro: RESP_MUX_TIMEOUT_EN.
- When defined:
  - A wait counter increments each cycle in PASS with data_valid=1, data_active=1 and the selected hreadyout=0. It clears on any other cycle.
  - When the counter reaches TIMEOUT_CYCLES (i.e. after TIMEOUT_CYCLES consecutive wait cycles), the next state is ERR1, timeout pulses high for one cycle, and the counter clears.
  - The late slave response is ignored from ERR1 onward.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- When undefined: no counter; timeout is tied to 0; a slave may stall indefinitely.

Test Plan:
1. NUM_SLAVES=4; channels hold hrdata 1,2,3,4; hreadyout all 1; hresp 1,0,0,1. NONSEQ with hsel_addr stepping 0,1,2,3 every cycle -> the cycle after each address phase shows hrdata=1,2,3,4 and hresp=1,0,0,1, one cycle delayed from hsel_addr.
2. Slave 2 holds hreadyout=0 for 3 cycles while the next address phase presents hsel_addr=1 -> data_sel stays 2 for those 3 cycles; hrdata=3 when hreadyout rises; data_sel=1 on the following cycle.
3. NONSEQ with hsel_valid=0 -> exactly two data-phase cycles: (hreadyout=0,hresp=1) then (hreadyout=1,hresp=1); hrdata=0; then PASS.
4. IDLE with hsel_valid=0, then NUM_SLAVES=5 with hsel_addr=6 and NONSEQ -> the IDLE gives an OKAY zero-wait response; the index-6 transfer gives the two-cycle ERROR.
5. hresetn pulled low during ERR1 and during a slave wait state -> outputs are immediately hrdata=0, hreadyout=1, hresp=0; data_sel=0; the next transfer after release behaves normally.
6. RESP_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=4; slave 0 holds hreadyout=0 forever -> after 4 wait cycles timeout pulses once, then ERR1 and ERR2; without the macro, hreadyout stays 0 and timeout stays 0.
